// File: rtl/dff_capture_checker.sv
// rtl/dff_capture_checker.sv - reference-model observer for a W-bit DFF with async active-high reset
module dff_capture_checker #(
  parameter int W           = 8,
  parameter int CW          = 16,
  parameter int NUM_SAMPLES = 0
) (
  input  logic          i_clk,
  input  logic          i_areset,
  input  logic          i_start,
  input  logic          i_stop,
  input  logic [W-1:0]  i_d_obs,
  input  logic [W-1:0]  i_q_obs,
  input  logic          i_rst_obs,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_pass,
  output logic          o_fail,
  output logic [CW-1:0] o_sample_cnt,
  output logic [CW-1:0] o_err_cnt,
  output logic [CW-1:0] o_first_err_idx,
  output logic [W-1:0]  o_first_err_exp,
  output logic [W-1:0]  o_first_err_got
);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

  localparam logic [CW-1:0] LP_ONE    = CW'(1);
  localparam logic [CW-1:0] LP_TARGET = CW'(NUM_SAMPLES);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_mdl;
  logic          r_mdl_valid;
  logic [CW-1:0] r_sample_cnt;
  logic [CW-1:0] r_err_cnt;
  logic [CW-1:0] r_first_idx;
  logic [W-1:0]  r_first_exp;
  logic [W-1:0]  r_first_got;

  logic          w_busy;
  logic          w_start_ok;
  logic          w_sample;
  logic          w_mism;
  logic          w_auto;
  logic [W-1:0]  w_exp;
  logic [CW-1:0] w_sc_inc;
  logic [CW-1:0] w_ec_inc;

  assign w_busy     = (r_state == S_WARM) || (r_state == S_RUN);
  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // The observed reset forces q low immediately, so it yields a sample even before the model is valid.
  assign w_sample = (r_state == S_RUN) && (i_rst_obs || r_mdl_valid);
  assign w_exp    = i_rst_obs ? '0 : r_mdl;
  assign w_mism   = w_sample && (i_q_obs != w_exp);

  assign w_sc_inc = (&r_sample_cnt) ? r_sample_cnt : r_sample_cnt + LP_ONE;
  assign w_ec_inc = (&r_err_cnt)    ? r_err_cnt    : r_err_cnt + LP_ONE;
  assign w_auto   = (NUM_SAMPLES != 0) && w_sample && (w_sc_inc == LP_TARGET);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_WARM;
      S_WARM: w_state_nxt = i_stop ? S_DONE : S_RUN;
      S_RUN:  if (i_stop || w_auto) w_state_nxt = S_DONE;
      S_DONE: if (i_start) w_state_nxt = S_WARM;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      r_state      <= S_IDLE;
      r_mdl        <= '0;
      r_mdl_valid  <= 1'b0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_first_idx  <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_mdl_valid  <= 1'b0;
        r_sample_cnt <= '0;
        r_err_cnt    <= '0;
        r_first_idx  <= '0;
        r_first_exp  <= '0;
        r_first_got  <= '0;
      end else begin
        if (w_busy) begin
          r_mdl       <= i_rst_obs ? '0 : i_d_obs;
          r_mdl_valid <= 1'b1;
        end
        if (w_sample) begin
          r_sample_cnt <= w_sc_inc;
          if (w_mism) begin
            r_err_cnt <= w_ec_inc;
            if (r_err_cnt == '0) begin
              r_first_idx <= r_sample_cnt;
              r_first_exp <= w_exp;
              r_first_got <= i_q_obs;
            end
          end
        end
      end
    end
  end

  assign o_busy          = w_busy;
  assign o_done          = (r_state == S_DONE);
  assign o_pass          = (r_state == S_DONE) && (r_err_cnt == '0);
  assign o_fail          = (r_err_cnt != '0);
  assign o_sample_cnt    = r_sample_cnt;
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_idx = r_first_idx;
  assign o_first_err_exp = r_first_exp;
  assign o_first_err_got = r_first_got;

endmodule

// File: tb/tb_dff_capture_checker.sv
// tb/tb_dff_capture_checker.sv - directed vector bench for dff_capture_checker
module tb_dff_capture_checker;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam int   NV = 22;

  logic       clk = 1'b0;
  logic       areset, start, stop, rst_obs;
  logic [7:0] d_obs, q_obs;

  logic        busy, done, pass, fail;
  logic [15:0] sample_cnt, err_cnt, first_err_idx;
  logic [7:0]  first_err_exp, first_err_got;

  logic        a_busy, a_done, a_pass, a_fail;
  logic [15:0] a_sc, a_ec, a_fidx;
  logic [7:0]  a_fexp, a_fgot;

  logic        s_busy, s_done, s_pass, s_fail;
  logic [1:0]  s_sc, s_ec, s_fidx;
  logic [7:0]  s_fexp, s_fgot;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dff_capture_checker u_dut (
    .i_clk(clk), .i_areset(areset), .i_start(start), .i_stop(stop),
    .i_d_obs(d_obs), .i_q_obs(q_obs), .i_rst_obs(rst_obs),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_fail(fail),
    .o_sample_cnt(sample_cnt), .o_err_cnt(err_cnt), .o_first_err_idx(first_err_idx),
    .o_first_err_exp(first_err_exp), .o_first_err_got(first_err_got)
  );

  dff_capture_checker #(.NUM_SAMPLES(5)) u_auto (
    .i_clk(clk), .i_areset(areset), .i_start(start), .i_stop(stop),
    .i_d_obs(d_obs), .i_q_obs(q_obs), .i_rst_obs(rst_obs),
    .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass), .o_fail(a_fail),
    .o_sample_cnt(a_sc), .o_err_cnt(a_ec), .o_first_err_idx(a_fidx),
    .o_first_err_exp(a_fexp), .o_first_err_got(a_fgot)
  );

  dff_capture_checker #(.CW(2)) u_sat (
    .i_clk(clk), .i_areset(areset), .i_start(start), .i_stop(stop),
    .i_d_obs(d_obs), .i_q_obs(q_obs), .i_rst_obs(rst_obs),
    .o_busy(s_busy), .o_done(s_done), .o_pass(s_pass), .o_fail(s_fail),
    .o_sample_cnt(s_sc), .o_err_cnt(s_ec), .o_first_err_idx(s_fidx),
    .o_first_err_exp(s_fexp), .o_first_err_got(s_fgot)
  );

  typedef struct {
    logic        start, stop, rst;
    logic [7:0]  d, q;
    logic        busy, done, pass, fail;
    logic [15:0] sc, ec, fidx;
    logic [7:0]  fexp, fgot;
  } vec_t;

  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, input logic sp, input logic rs,
                       input logic [7:0] d, input logic [7:0] q);
    start = st; stop = sp; rst_obs = rs; d_obs = d; q_obs = q;
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    areset = 1'b1;
    drive(L, L, L, 8'h00, 8'h00);
    areset = 1'b0;
  endtask

  task automatic chk_main_zero(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'(0));
    chk({tag, " done"}, 32'(done), 32'(0));
    chk({tag, " pass"}, 32'(pass), 32'(0));
    chk({tag, " fail"}, 32'(fail), 32'(0));
    chk({tag, " sample_cnt"}, 32'(sample_cnt), 32'(0));
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(0));
    chk({tag, " first_err_idx"}, 32'(first_err_idx), 32'(0));
    chk({tag, " first_err_exp"}, 32'(first_err_exp), 32'(0));
    chk({tag, " first_err_got"}, 32'(first_err_got), 32'(0));
  endtask

  initial begin
    //          start stop rst  d      q      busy done pass fail sc  ec  fidx fexp   fgot
    vecs[0]  = '{H, L, L, 8'h55, 8'h00, H, L, L, L, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[1]  = '{L, L, L, 8'h55, 8'h55, H, L, L, L, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[2]  = '{L, L, L, 8'h55, 8'h55, H, L, L, L, 16'd1, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[3]  = '{H, L, L, 8'h55, 8'h55, H, L, L, L, 16'd2, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[4]  = '{L, H, L, 8'h55, 8'h55, L, H, H, L, 16'd3, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[5]  = '{L, L, L, 8'h55, 8'h55, L, H, H, L, 16'd3, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[6]  = '{H, L, H, 8'h00, 8'h00, H, L, L, L, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[7]  = '{L, L, H, 8'h00, 8'h00, H, L, L, L, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[8]  = '{L, L, H, 8'hAA, 8'h00, H, L, L, L, 16'd1, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[9]  = '{L, L, L, 8'hAA, 8'h00, H, L, L, L, 16'd2, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[10] = '{L, L, L, 8'hAA, 8'hAA, H, L, L, L, 16'd3, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[11] = '{L, H, L, 8'hAA, 8'hAA, L, H, H, L, 16'd4, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[12] = '{H, L, L, 8'h55, 8'hAA, H, L, L, L, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[13] = '{L, L, L, 8'h55, 8'h55, H, L, L, L, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[14] = '{L, L, L, 8'h55, 8'h55, H, L, L, L, 16'd1, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[15] = '{L, L, L, 8'h55, 8'h55, H, L, L, L, 16'd2, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[16] = '{L, L, L, 8'h55, 8'h54, H, L, L, H, 16'd3, 16'd1, 16'd2, 8'h55, 8'h54};
    vecs[17] = '{L, L, L, 8'h55, 8'h00, H, L, L, H, 16'd4, 16'd2, 16'd2, 8'h55, 8'h54};
    vecs[18] = '{L, H, L, 8'h55, 8'h55, L, H, L, H, 16'd5, 16'd2, 16'd2, 8'h55, 8'h54};
    vecs[19] = '{L, H, L, 8'h55, 8'h55, L, H, L, H, 16'd5, 16'd2, 16'd2, 8'h55, 8'h54};
    vecs[20] = '{H, L, L, 8'h11, 8'h55, H, L, L, L, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00};
    vecs[21] = '{L, H, L, 8'h11, 8'h11, L, H, H, L, 16'd0, 16'd0, 16'd0, 8'h00, 8'h00};

    areset = 1'b1; start = 1'b0; stop = 1'b0; rst_obs = 1'b0; d_obs = 8'h00; q_obs = 8'h00;
    repeat (3) @(negedge clk);
    chk_main_zero("reset");
    areset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].rst, vecs[i].d, vecs[i].q);
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].done));
      chk($sformatf("v%0d pass", i), 32'(pass), 32'(vecs[i].pass));
      chk($sformatf("v%0d fail", i), 32'(fail), 32'(vecs[i].fail));
      chk($sformatf("v%0d sample_cnt", i), 32'(sample_cnt), 32'(vecs[i].sc));
      chk($sformatf("v%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].ec));
      chk($sformatf("v%0d first_err_idx", i), 32'(first_err_idx), 32'(vecs[i].fidx));
      chk($sformatf("v%0d first_err_exp", i), 32'(first_err_exp), 32'(vecs[i].fexp));
      chk($sformatf("v%0d first_err_got", i), 32'(first_err_got), 32'(vecs[i].fgot));
    end

    // Auto-finish after five samples on the NUM_SAMPLES=5 instance.
    reset_pulse();
    drive(H, L, L, 8'h33, 8'h00);
    drive(L, L, L, 8'h33, 8'h33);
    for (int k = 1; k <= 5; k++) begin
      drive(L, L, L, 8'h33, 8'h33);
      chk($sformatf("auto s%0d sample_cnt", k), 32'(a_sc), 32'(k));
      chk($sformatf("auto s%0d done", k), 32'(a_done), 32'(k == 5));
    end
    drive(L, L, L, 8'h33, 8'h33);
    chk("auto hold sample_cnt", 32'(a_sc), 32'(5));
    chk("auto hold pass", 32'(a_pass), 32'(1));

    // areset mid-run overrides start/stop; a later stop stays ignored.
    reset_pulse();
    drive(H, L, L, 8'h00, 8'h00);
    drive(L, L, L, 8'h00, 8'h00);
    repeat (3) drive(L, L, L, 8'h00, 8'h0F);
    chk("areset pre err_cnt", 32'(err_cnt), 32'(3));
    chk("areset pre fail", 32'(fail), 32'(1));
    chk("areset pre busy", 32'(busy), 32'(1));
    areset = 1'b1;
    drive(H, H, L, 8'h00, 8'h0F);
    areset = 1'b0;
    chk_main_zero("areset");
    drive(L, H, L, 8'h00, 8'h00);
    chk("post areset stop busy", 32'(busy), 32'(0));
    chk("post areset stop done", 32'(done), 32'(0));

    // Saturation on the CW=2 instance.
    reset_pulse();
    drive(H, L, L, 8'h00, 8'h00);
    drive(L, L, L, 8'h00, 8'h00);
    for (int k = 1; k <= 6; k++) begin
      drive(L, L, L, 8'h00, 8'hFF);
      chk($sformatf("sat m%0d err_cnt", k), 32'(s_ec), 32'((k < 3) ? k : 3));
    end
    chk("sat sample_cnt", 32'(s_sc), 32'(3));
    chk("sat first_err_idx", 32'(s_fidx), 32'(0));
    chk("sat first_err_exp", 32'(s_fexp), 32'(8'h00));
    chk("sat first_err_got", 32'(s_fgot), 32'(8'hFF));
    drive(L, H, L, 8'h00, 8'h00);
    chk("sat done", 32'(s_done), 32'(1));
    chk("sat pass", 32'(s_pass), 32'(0));
    chk("sat fail", 32'(s_fail), 32'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
